spi_master: RTL and testbench

SPI bus initiator that generates `ss`, `scl` and `mosi` and captures `miso` for one fixed-width word per request. The SPI mode is set at elaboration by CPOL/CPHA, and `scl` is a divided copy of the system clock. It is the host-side counterpart of the team's SPI slave and plugs straight into that block's `scl`/`ss`/`mosi`/`miso` pins. Local logic requests a transfer with a start/busy/done handshake.

---
 rtl/spi_master.sv | 182 ++++++++++++++++++
 tb/tb_spi_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI bus initiator: one DATA_W-bit full-duplex word per start/done handshake.
// The SPI mode is fixed by CPOL/CPHA. scl is clk divided by 2*CLK_DIV.
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   start, tx_data   transfer request and word to send (taken in IDLE only)
//   busy, done       busy from the cycle after acceptance; done is a 1-cycle pulse
//   rx_data          last received word, updated together with done
//   ss, scl, mosi    registered bus outputs (ss active low)
//   miso             serial data in
module spi_master #(
  parameter int unsigned CPOL    = 1,
  parameter int unsigned CPHA    = 1,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss,
  output logic              scl,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic              IDLE_LVL  = 1'(CPOL);
  // Odd (leading) edges are sampling edges when CPHA=0.
  localparam logic              SAMPLE_ODD = (CPHA == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                ss_q, ss_d;
  logic                scl_q, scl_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tick;
  logic                do_edge;
  logic [EDGE_W-1:0]   edge_num;
  logic                is_sample;
  logic                launch_ok;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      ss_q    <= 1'b1;
      scl_q   <= IDLE_LVL;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      ss_q    <= ss_d;
      scl_q   <= scl_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, scl edge generation and shift logic.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q + DIV_W'(1);
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    ss_d      = ss_q;
    scl_d     = scl_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    do_edge   = 1'b0;
    tick      = (div_q == DIV_LAST);
    edge_num  = edge_q + EDGE_ONE;
    is_sample = (edge_num[0] == SAMPLE_ODD);
    // CPHA=0 skips the final trailing edge; CPHA=1 skips the first leading
    // edge because the MSB is already on mosi from acceptance.
    launch_ok = (CPHA == 0) ? (edge_num != EDGE_LAST) : (edge_num != EDGE_ONE);

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (start) begin
          state_d = S_LEAD;
          tx_d    = tx_data;
          rx_sh_d = '0;
          edge_d  = '0;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = tx_data[DATA_W-1];
        end
      end
      S_LEAD: begin
        if (tick) begin
          div_d   = '0;
          do_edge = 1'b1;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (tick) begin
          div_d   = '0;
          do_edge = 1'b1;
          if (edge_num == EDGE_LAST) state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (tick) begin
          div_d   = '0;
          state_d = S_GAP;
          ss_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rx_d    = rx_sh_q;
          tx_d    = '0;
          mosi_d  = 1'b0;
        end
      end
      S_GAP: begin
        if (tick) begin
          div_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An scl edge either captures miso or advances the tx word.
    if (do_edge) begin
      scl_d  = ~scl_q;
      edge_d = edge_num;
      if (is_sample) begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
      end else if (launch_ok) begin
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        mosi_d = tx_q[DATA_W-2];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign ss      = ss_q;
  assign scl     = scl_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: five instances cover all SPI modes and a
// CLK_DIV=1/DATA_W=16 variant. A clk-synchronous slave model watches scl
// edges, feeds miso from a slave word and collects mosi on sampling edges.
module tb_spi_master;

  localparam int N = 5;

  function automatic int unsigned cpol_of(int i);
    return (i == 1 || i == 2) ? 0 : 1;
  endfunction
  function automatic int unsigned cpha_of(int i);
    return (i == 1 || i == 3) ? 0 : 1;
  endfunction
  function automatic int unsigned dw_of(int i);
    return (i == 4) ? 16 : 8;
  endfunction
  function automatic int unsigned cd_of(int i);
    return (i == 4) ? 1 : 2;
  endfunction

  logic          clk;
  logic          rstn;
  logic [N-1:0]  start;
  logic [N-1:0]  miso;
  logic [15:0]   tx_word [N];
  wire  [N-1:0]  busy, done, ss, scl, mosi;
  wire  [15:0]   rx_w [N];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Slave model / monitor state, one entry per instance.
  logic [15:0] slave_word [N];
  logic [15:0] cap [N];
  logic [15:0] last_cap [N];
  logic [15:0] prev_cap [N];
  logic [15:0] done_rx [N];
  int edges [N], rise_n [N], fall_n [N], sbit [N];
  int ss_fall_cyc [N], ss_rise_cyc [N], done_cyc [N], done_cnt [N];
  int first_edge_cyc [N], last_edge_cyc [N], idle_bad [N];
  logic busy_at_done [N];
  logic [N-1:0] prev_ss, prev_scl;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned DW = dw_of(g);
    logic [DW-1:0] rx_l;
    spi_master #(
      .CPOL   (cpol_of(g)),
      .CPHA   (cpha_of(g)),
      .DATA_W (DW),
      .CLK_DIV(cd_of(g))
    ) u_dut (
      .clk    (clk),
      .rstn   (rstn),
      .start  (start[g]),
      .tx_data(DW'(tx_word[g])),
      .busy   (busy[g]),
      .done   (done[g]),
      .rx_data(rx_l),
      .ss     (ss[g]),
      .scl    (scl[g]),
      .mosi   (mosi[g]),
      .miso   (miso[g])
    );
    assign rx_w[g] = 16'(rx_l);
  end

  // Behavioural SPI slave and bus monitor, evaluated mid-cycle.
  initial begin
    for (int i = 0; i < N; i++) begin
      slave_word[i] = '0; cap[i] = '0; last_cap[i] = '0; prev_cap[i] = '0;
      done_rx[i] = '0; edges[i] = 0; rise_n[i] = 0; fall_n[i] = 0; sbit[i] = -1;
      ss_fall_cyc[i] = 0; ss_rise_cyc[i] = 0; done_cyc[i] = 0; done_cnt[i] = 0;
      first_edge_cyc[i] = 0; last_edge_cyc[i] = 0; idle_bad[i] = 0;
      busy_at_done[i] = 1'b0;
      prev_ss[i] = 1'b1; prev_scl[i] = 1'(cpol_of(i)); miso[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        bit is_lead, is_sample;
        if (prev_ss[i] && !ss[i]) begin
          ss_fall_cyc[i] = cyc; edges[i] = 0; rise_n[i] = 0; fall_n[i] = 0;
          cap[i] = '0; sbit[i] = int'(dw_of(i)) - 1;
          if (cpha_of(i) == 0) begin
            miso[i] = slave_word[i][sbit[i]];
            sbit[i]--;
          end
        end
        if (!prev_ss[i] && ss[i]) begin
          ss_rise_cyc[i] = cyc; prev_cap[i] = last_cap[i]; last_cap[i] = cap[i];
        end
        if (!ss[i] && scl[i] != prev_scl[i]) begin
          edges[i]++;
          if (edges[i] == 1) first_edge_cyc[i] = cyc;
          last_edge_cyc[i] = cyc;
          if (scl[i]) rise_n[i]++; else fall_n[i]++;
          is_lead   = (scl[i] != 1'(cpol_of(i)));
          is_sample = (cpha_of(i) == 0) ? is_lead : !is_lead;
          if (is_sample) begin
            cap[i] = {cap[i][14:0], mosi[i]};
          end else if (sbit[i] >= 0) begin
            miso[i] = slave_word[i][sbit[i]];
            sbit[i]--;
          end
        end
        if (rstn && ss[i] && scl[i] != 1'(cpol_of(i))) idle_bad[i]++;
        if (done[i]) begin
          done_cnt[i]++; done_cyc[i] = cyc; busy_at_done[i] = busy[i]; done_rx[i] = rx_w[i];
        end
        prev_ss[i] = ss[i]; prev_scl[i] = scl[i];
      end
    end
  end

  // Start one transfer on instance i and wait (bounded) until it is back in IDLE.
  task automatic run_xfer(input int i, input logic [15:0] txw, input logic [15:0] sw,
                          output int t0, output bit timed_out);
    int d0;
    slave_word[i] = sw;
    @(negedge clk); #1;
    tx_word[i] = txw; start[i] = 1'b1; t0 = cyc; d0 = done_cnt[i];
    @(negedge clk); #1;
    start[i] = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if (done_cnt[i] != d0) begin timed_out = 1'b0; break; end
      @(negedge clk); #1;
    end
    repeat (int'(cd_of(i)) + 2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = '0;
    for (int i = 0; i < N; i++) tx_word[i] = '0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (20) begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        logic [4:0] obs, expv;
        obs  = {ss[i], scl[i], mosi[i], busy[i], done[i]};
        expv = {1'b1, 1'(cpol_of(i)), 3'b000};
        checks++;
        if (obs !== expv) begin
          failures++;
          $display("FAIL reset_idle inst%0d {ss,scl,mosi,busy,done}: got %b expected %b", i, obs, expv);
        end
        checks++;
        if (rx_w[i] !== 16'h0) begin
          failures++;
          $display("FAIL reset_rx inst%0d: got %h expected 0000", i, rx_w[i]);
        end
      end
    end
  endtask

  task automatic test_mode3();
    int t0; bit to; int exp_done;
    run_xfer(0, 16'h005A, 16'h00C3, t0, to);
    exp_done = t0 + 1 + (2 * 8 + 1) * 2;
    checks++;
    if (to) begin failures++; $display("FAIL mode3_timeout: got timeout expected done"); end
    checks++;
    if (ss_fall_cyc[0] != t0 + 1) begin
      failures++; $display("FAIL mode3_ss_fall: got cycle %0d expected %0d", ss_fall_cyc[0], t0 + 1);
    end
    checks++;
    if (done_cyc[0] != exp_done) begin
      failures++; $display("FAIL mode3_done_time: got cycle %0d expected %0d", done_cyc[0], exp_done);
    end
    checks++;
    if (done_rx[0] !== 16'h00C3 || rx_w[0] !== 16'h00C3) begin
      failures++; $display("FAIL mode3_rx: got %h/%h expected 00c3", done_rx[0], rx_w[0]);
    end
    checks++;
    if (last_cap[0] !== 16'h005A) begin
      failures++; $display("FAIL mode3_mosi_bits: got %h expected 005a", last_cap[0]);
    end
    checks++;
    if (rise_n[0] != 8 || fall_n[0] != 8) begin
      failures++; $display("FAIL mode3_edges: got rise=%0d fall=%0d expected 8/8", rise_n[0], fall_n[0]);
    end
    checks++;
    if (busy_at_done[0] !== 1'b0) begin
      failures++; $display("FAIL mode3_busy_at_done: got %b expected 0", busy_at_done[0]);
    end
  endtask

  task automatic test_modes();
    for (int i = 0; i < 4; i++) begin
      int t0; bit to;
      run_xfer(i, 16'h00A5, 16'h003C, t0, to);
      checks++;
      if (to || done_rx[i] !== 16'h003C || last_cap[i] !== 16'h00A5) begin
        failures++;
        $display("FAIL mode_loopback inst%0d: got rx=%h mosi=%h timeout=%0d expected rx=003c mosi=00a5",
                 i, done_rx[i], last_cap[i], to);
      end
      checks++;
      if (idle_bad[i] != 0 || scl[i] !== 1'(cpol_of(i))) begin
        failures++;
        $display("FAIL mode_scl_idle inst%0d: got bad=%0d scl=%b expected 0/%0d", i, idle_bad[i], scl[i], cpol_of(i));
      end
      checks++;
      if (edges[i] != 16) begin
        failures++; $display("FAIL mode_edge_count inst%0d: got %0d expected 16", i, edges[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) begin
        int t0; bit to; int exp_done;
        logic [15:0] txw, sw, mask;
        mask = (dw_of(i) == 16) ? 16'hFFFF : 16'h00FF;
        txw = 16'($urandom) & mask;
        sw  = 16'($urandom) & mask;
        run_xfer(i, txw, sw, t0, to);
        exp_done = t0 + 1 + int'((2 * dw_of(i) + 1) * cd_of(i));
        checks++;
        if (to || done_rx[i] !== sw || last_cap[i] !== txw || done_cyc[i] != exp_done) begin
          failures++;
          $display("FAIL random inst%0d: got rx=%h mosi=%h done@%0d expected rx=%h mosi=%h done@%0d",
                   i, done_rx[i], last_cap[i], done_cyc[i], sw, txw, exp_done);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, c, sw;
    int t0, d0, done1, rise1, fall2;
    bit to;
    a  = 16'($urandom_range(0, 255));
    b  = 16'($urandom_range(0, 255)) ^ 16'h0081;
    c  = ~b & 16'h00FF;
    sw = 16'($urandom_range(0, 255));
    slave_word[0] = sw; d0 = done_cnt[0];
    @(negedge clk); #1;
    tx_word[0] = a; start[0] = 1'b1; t0 = cyc;
    @(negedge clk); #1;
    tx_word[0] = b;
    to = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (done_cnt[0] == d0 + 1) begin to = 1'b0; break; end
      @(negedge clk); #1;
    end
    done1 = done_cyc[0]; rise1 = ss_rise_cyc[0];
    checks++;
    if (to || done1 != t0 + 35) begin
      failures++; $display("FAIL b2b_first_done: got cycle %0d timeout=%0d expected %0d", done1, to, t0 + 35);
    end
    to = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (ss_fall_cyc[0] > done1) begin to = 1'b0; break; end
      @(negedge clk); #1;
    end
    fall2 = ss_fall_cyc[0];
    tx_word[0] = c; start[0] = 1'b0;
    // Next acceptance is CLK_DIV cycles after done; ss falls one cycle later.
    checks++;
    if (to || fall2 - done1 != 3 || fall2 - rise1 != 3) begin
      failures++;
      $display("FAIL b2b_gap: got done->ss_fall=%0d rise->fall=%0d timeout=%0d expected 3/3", fall2 - done1, fall2 - rise1, to);
    end
    for (int n = 0; n < 200; n++) begin
      if (done_cnt[0] == d0 + 2) break;
      @(negedge clk); #1;
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (done_cnt[0] != d0 + 2) begin
      failures++; $display("FAIL b2b_done_count: got %0d expected %0d", done_cnt[0] - d0, 2);
    end
    checks++;
    if (prev_cap[0] !== a || last_cap[0] !== b) begin
      failures++; $display("FAIL b2b_tx_words: got %h,%h expected %h,%h", prev_cap[0], last_cap[0], a, b);
    end
    checks++;
    if (done_rx[0] !== sw) begin
      failures++; $display("FAIL b2b_rx: got %h expected %h", done_rx[0], sw);
    end
  endtask

  task automatic test_reset_mid();
    int t0; bit to;
    logic [15:0] sw;
    logic [4:0] obs;
    slave_word[0] = 16'h0066;
    @(negedge clk); #1;
    tx_word[0] = 16'h0099; start[0] = 1'b1;
    @(negedge clk); #1;
    start[0] = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (edges[0] == 7) begin to = 1'b0; break; end
      @(negedge clk); #1;
    end
    rstn = 1'b0;
    #1;
    obs = {ss[0], scl[0], mosi[0], busy[0], done[0]};
    checks++;
    if (to || obs !== 5'b11000 || rx_w[0] !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid: got {ss,scl,mosi,busy,done}=%b rx=%h timeout=%0d expected 11000 rx=0000", obs, rx_w[0], to);
    end
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    sw = 16'($urandom_range(0, 255));
    run_xfer(0, 16'h00FF, sw, t0, to);
    checks++;
    if (to || last_cap[0] !== 16'h00FF || done_rx[0] !== sw || done_cyc[0] != t0 + 35) begin
      failures++;
      $display("FAIL reset_recover: got mosi=%h rx=%h done@%0d expected mosi=00ff rx=%h done@%0d",
               last_cap[0], done_rx[0], done_cyc[0], sw, t0 + 35);
    end
  endtask

  task automatic test_div1();
    int t0; bit to;
    logic [15:0] sw;
    sw = 16'($urandom);
    run_xfer(4, 16'h8001, sw, t0, to);
    checks++;
    if (to || done_cyc[4] != t0 + 34) begin
      failures++; $display("FAIL div1_done_time: got cycle %0d expected %0d", done_cyc[4], t0 + 34);
    end
    checks++;
    if (edges[4] != 32 || last_edge_cyc[4] - first_edge_cyc[4] != 31) begin
      failures++;
      $display("FAIL div1_scl_toggle: got edges=%0d span=%0d expected 32/31", edges[4], last_edge_cyc[4] - first_edge_cyc[4]);
    end
    checks++;
    if (last_cap[4] !== 16'h8001 || done_rx[4] !== sw) begin
      failures++; $display("FAIL div1_data: got mosi=%h rx=%h expected 8001/%h", last_cap[4], done_rx[4], sw);
    end
  endtask

  initial begin
    test_reset();
    test_mode3();
    test_modes();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
